// File: rtl/mem_fsm.sv
// Single-port BRAM access controller: level-held read/write requests in, registered done/data out.
// Reads take three clocks because the BRAM read port is registered; writes take two.
module mem_fsm_bram #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  output logic [DATA_BITS-1:0] rdata_o
);

  logic [DATA_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];

  // Contents are deliberately not reset; the read port is read-first and registered.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_o <= mem[addr_i];
  end

endmodule

module mem_fsm #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          addr,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 start_read,
  input  logic                 start_write,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 done_q, done_d;
  logic                 bram_we;
  logic [DATA_BITS-1:0] bram_rdata;

  generate
    if (ADDR_BITS < 16) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^addr[15:ADDR_BITS];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  // Requests are only sampled in IDLE, so later input changes cannot disturb an access in flight.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (start_read) begin
          addr_d  = addr[ADDR_BITS-1:0];
          state_d = RD_ADDR;
        end else if (start_write) begin
          addr_d  = addr[ADDR_BITS-1:0];
          wdata_d = data_in;
          state_d = WR;
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: state_d = DONE;
      WR:      state_d = DONE;
      DONE: begin
        if (!(start_read || start_write)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bram_we    = (state_q == WR);
    done_d     = (state_d == DONE);
    data_out_d = (state_q == RD_DATA) ? bram_rdata : data_out_q;
  end

  mem_fsm_bram #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) bram_inst (
    .clk     (clk),
    .we_i    (bram_we),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (bram_rdata)
  );

  assign data_out = data_out_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mem_fsm.sv
// Directed bench for mem_fsm: a table of complete transactions plus hand-written
// sequences for capture, short pulses and reset aborts.
module tb_mem_fsm;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] dataIn;
  logic        startRead;
  logic        startWrite;
  logic [15:0] dataOut;
  logic        done;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] dataIn;
    logic [15:0] expData;
    int          expLat;
    int          memIdx;
    logic [15:0] expMem;
  } vecT;

  vecT vecs[10];

  mem_fsm #(.ADDR_BITS(8), .DATA_BITS(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .data_in     (dataIn),
    .start_read  (startRead),
    .start_write (startWrite),
    .data_out    (dataOut),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one full handshake: request, wait for done, check, hold one extra clock, release.
  task automatic applyStimulus(input vecT v);
    int cycles;
    cycles = 0;
    @(negedge clk);
    addr       = v.addr;
    dataIn     = v.dataIn;
    startRead  = v.rd;
    startWrite = v.wr;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < 10);
    checkOutput("latency", cycles, v.expLat);
    checkOutput("done_set", {31'b0, done}, 32'd1);
    checkOutput("data_out", {16'b0, dataOut}, {16'b0, v.expData});
    checkOutput("mem", {16'b0, dut.bram_inst.mem[v.memIdx]}, {16'b0, v.expMem});
    @(negedge clk);
    checkOutput("done_held", {31'b0, done}, 32'd1);
    startRead  = 1'b0;
    startWrite = 1'b0;
    @(negedge clk);
    checkOutput("done_release", {31'b0, done}, 32'd0);
    checkOutput("data_hold", {16'b0, dataOut}, {16'b0, v.expData});
  endtask

  initial begin
    vecT extra;

    //            rd    wr    addr      dataIn    expData   lat idx  expMem
    vecs[0] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 3, 0,   16'hFFFF};
    vecs[1] = '{1'b0, 1'b1, 16'h0001, 16'hFFFF, 16'hFFFF, 2, 1,   16'hFFFF};
    vecs[2] = '{1'b1, 1'b1, 16'h0002, 16'hABCD, 16'h1234, 3, 2,   16'h1234};
    vecs[3] = '{1'b0, 1'b1, 16'h0003, 16'h5A5A, 16'h1234, 2, 3,   16'h5A5A};
    vecs[4] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'h5A5A, 3, 3,   16'h5A5A};
    vecs[5] = '{1'b0, 1'b1, 16'h00FF, 16'hBEEF, 16'h5A5A, 2, 255, 16'hBEEF};
    vecs[6] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'hBEEF, 3, 255, 16'hBEEF};
    vecs[7] = '{1'b1, 1'b0, 16'hFF01, 16'h0000, 16'hFFFF, 3, 1,   16'hFFFF};
    vecs[8] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h0000, 3, 4,   16'h0000};
    vecs[9] = '{1'b0, 1'b1, 16'h1204, 16'h0BAD, 16'h0000, 2, 4,   16'h0BAD};

    rst        = 1'b0;
    addr       = '0;
    dataIn     = '0;
    startRead  = 1'b0;
    startWrite = 1'b0;
    for (int i = 0; i < 256; i++) dut.bram_inst.mem[i] = 16'h0000;
    dut.bram_inst.mem[0] = 16'hFFFF;
    dut.bram_inst.mem[2] = 16'h1234;

    #1;
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_data", {16'b0, dataOut}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Address changed after capture must not redirect the read.
    @(negedge clk);
    addr      = 16'h0003;
    startRead = 1'b1;
    @(negedge clk);
    addr   = 16'h0000;
    dataIn = 16'hDEAD;
    @(negedge clk);
    checkOutput("capture_not_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    checkOutput("capture_done", {31'b0, done}, 32'd1);
    checkOutput("capture_data", {16'b0, dataOut}, 32'h5A5A);
    startRead = 1'b0;
    @(negedge clk);
    checkOutput("capture_release", {31'b0, done}, 32'd0);

    // One-cycle write pulse still completes and passes through DONE once.
    @(negedge clk);
    addr       = 16'h0005;
    dataIn     = 16'h1111;
    startWrite = 1'b1;
    @(negedge clk);
    startWrite = 1'b0;
    @(negedge clk);
    checkOutput("pulse_done", {31'b0, done}, 32'd1);
    checkOutput("pulse_mem", {16'b0, dut.bram_inst.mem[5]}, 32'h1111);
    @(negedge clk);
    checkOutput("pulse_drop", {31'b0, done}, 32'd0);
    checkOutput("pulse_data", {16'b0, dataOut}, 32'h5A5A);

    // Reset in RD_DATA clears outputs without a clock edge.
    @(negedge clk);
    addr      = 16'h0002;
    startRead = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_done", {31'b0, done}, 32'd0);
    checkOutput("rst_mid_data", {16'b0, dataOut}, 32'h0000);
    startRead = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_idle_done", {31'b0, done}, 32'd0);
    checkOutput("rst_idle_data", {16'b0, dataOut}, 32'h0000);

    // Reset while in WR must not commit the word.
    @(negedge clk);
    addr       = 16'h0006;
    dataIn     = 16'h7777;
    startWrite = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    startWrite = 1'b0;
    @(negedge clk);
    checkOutput("abort_mem", {16'b0, dut.bram_inst.mem[6]}, 32'h0000);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("abort_done", {31'b0, done}, 32'd0);

    extra = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1111, 3, 5, 16'h1111};
    applyStimulus(extra);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
